// File: rtl/rx_core_demux_if.sv
// rx_core_demux_if: bundle of the wide ADC input stream, the three 128-bit
// channel output streams, the channel enable mask and the beat counter.
//   adc_tvalid/adc_tdata[255:0]/adc_tready  wide input stream
//   chan_enable[2:0]                        channel enable mask (bit0 = ch1)
//   chN_tvalid/chN_tdata[127:0]/chN_tready  per-channel output streams
//   beat_count[CNT_WIDTH-1:0]               accepted input beat counter
// slave: the demux side; master: the environment driving it.
interface rx_core_demux_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 adc_tvalid;
    logic [255:0]         adc_tdata;
    logic                 adc_tready;
    logic [2:0]           chan_enable;
    logic                 ch1_tvalid;
    logic                 ch2_tvalid;
    logic                 ch3_tvalid;
    logic [127:0]         ch1_tdata;
    logic [127:0]         ch2_tdata;
    logic [127:0]         ch3_tdata;
    logic                 ch1_tready;
    logic                 ch2_tready;
    logic                 ch3_tready;
    logic [CNT_WIDTH-1:0] beat_count;

    modport slave (
        input  adc_tvalid, adc_tdata, chan_enable,
        input  ch1_tready, ch2_tready, ch3_tready,
        output adc_tready,
        output ch1_tvalid, ch2_tvalid, ch3_tvalid,
        output ch1_tdata, ch2_tdata, ch3_tdata,
        output beat_count
    );

    modport master (
        output adc_tvalid, adc_tdata, chan_enable,
        output ch1_tready, ch2_tready, ch3_tready,
        input  adc_tready,
        input  ch1_tvalid, ch2_tvalid, ch3_tvalid,
        input  ch1_tdata, ch2_tdata, ch3_tdata,
        input  beat_count
    );
endinterface

// File: rtl/rx_core_demux.sv
// rx_core_demux: splits each accepted 256-bit ADC beat into two 128-bit
// halves (low first) and routes each half to one enabled channel, chosen
// round-robin among channels 1..3.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rx_core_demux_if.slave (input stream, channel streams, enables,
//        beat counter)
module rx_core_demux #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    rx_core_demux_if.slave  bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOW   = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           rr;
    logic [1:0]           dest;
    logic [1:0]           rr_next;
    logic [255:0]         hold;
    logic [CNT_WIDTH-1:0] count;
    logic                 run;
    logic                 dest_ready;
    logic                 accept;

    // First enabled channel searching cyclically from start; fallback when
    // nothing is enabled.
    function automatic logic [1:0] pick(input logic [1:0] start,
                                        input logic [2:0] en,
                                        input logic [1:0] fallback);
        logic [1:0] c;
        logic       found;
        pick  = fallback;
        found = 1'b0;
        c     = start;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && en[c - 2'd1]) begin
                pick  = c;
                found = 1'b1;
            end
            c = (c == 2'd3) ? 2'd1 : c + 2'd1;
        end
    endfunction

    always_comb begin
        dest_ready = 1'b0;
        case (dest)
            2'd1:    dest_ready = bus.ch1_tready;
            2'd2:    dest_ready = bus.ch2_tready;
            2'd3:    dest_ready = bus.ch3_tready;
            default: dest_ready = 1'b0;
        endcase
    end

    assign rr_next = (dest == 2'd3) ? 2'd1 : dest + 2'd1;

    // run holds ready low until the first edge after reset is released.
    assign bus.adc_tready = run && (bus.chan_enable != 3'b000) &&
                            ((state == EMPTY) || ((state == HIGH) && dest_ready));
    assign accept = bus.adc_tvalid && bus.adc_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            rr    <= 2'd1;
            dest  <= 2'd1;
            hold  <= '0;
            count <= '0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                hold  <= bus.adc_tdata;
                count <= count + 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= LOW;
                        dest  <= pick(rr, bus.chan_enable, dest);
                    end
                end
                LOW: begin
                    if (dest_ready) begin
                        state <= HIGH;
                        rr    <= rr_next;
                        // Keeps the low half's channel if nothing is enabled.
                        dest  <= pick(rr_next, bus.chan_enable, dest);
                    end
                end
                HIGH: begin
                    if (dest_ready) begin
                        rr <= rr_next;
                        if (accept) begin
                            state <= LOW;
                            dest  <= pick(rr_next, bus.chan_enable, dest);
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    logic [127:0] half;
    assign half = (state == HIGH) ? hold[255:128] : hold[127:0];

    assign bus.ch1_tvalid = (state != EMPTY) && (dest == 2'd1);
    assign bus.ch2_tvalid = (state != EMPTY) && (dest == 2'd2);
    assign bus.ch3_tvalid = (state != EMPTY) && (dest == 2'd3);
    assign bus.ch1_tdata  = half;
    assign bus.ch2_tdata  = half;
    assign bus.ch3_tdata  = half;
    assign bus.beat_count = count;
endmodule

// File: doc/rx_core_demux.md
RX_CORE_DEMUX -- requirements
Module: rx_core_demux

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the accepted-beat counter.
REQ-002 clock  input  1  single clock; all state is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 adc_tvalid  input  1  wide input stream valid.
REQ-005 adc_tdata  input  256  wide input beat: bits [127:0] are the low half, bits [255:128] are the high half.
REQ-006 adc_tready  output  1  input ready.
REQ-007 chan_enable  input  3  enable mask for channels 1..3; bit0 is ch1.
REQ-008 ch1_tvalid, ch2_tvalid, ch3_tvalid  output  1 each  per-channel output valid.
REQ-009 ch1_tdata, ch2_tdata, ch3_tdata  output  128 each  per-channel output data.
REQ-010 ch1_tready, ch2_tready, ch3_tready  input  1 each  per-channel output ready.
REQ-011 beat_count  output  CNT_WIDTH  count of accepted input beats.

Function
REQ-012 Block SHALL split each accepted 256-bit beat into two 128-bit halves, low half first, and route each half to exactly one enabled channel.
REQ-013 State machine SHALL have three states:
- EMPTY: no data held.
- LOW: low half pending.
- HIGH: high half pending.
REQ-014 Input acceptance SHALL occur when adc_tvalid and adc_tready are both high; the full beat SHALL be registered into a 256-bit holding register.
REQ-015 adc_tready SHALL be high when chan_enable is nonzero and either:
- state is EMPTY, or
- state is HIGH and the destination channel's tready is high.
REQ-016 adc_tready SHALL be low when chan_enable is 3'b000.
REQ-017 On acceptance from EMPTY or HIGH, the next state SHALL be LOW. The low half SHALL appear on the outputs the cycle after acceptance (1-cycle latency).
REQ-018 LOW SHALL move to HIGH, and HIGH SHALL move to EMPTY (or to LOW on a simultaneous acceptance), only when the destination channel's tready is high.
REQ-019 Destination register dest (one of 1..3) SHALL be latched on entry to LOW and on entry to HIGH. It SHALL NOT change while its half is pending.
REQ-020 Destination selection: dest = first channel enabled in chan_enable searching cyclically from rr (1->2->3->1).
- After each half is emitted, rr = dest+1, wrapping 3->1.
- If no channel is enabled when dest is latched for a high half, dest SHALL equal the low half's dest.
REQ-021 Only ch<dest>_tvalid SHALL be high, and only in LOW or HIGH. All other tvalids SHALL be low.
REQ-022 All three chN_tdata SHALL carry the pending half: [127:0] in LOW, [255:128] in HIGH. They SHALL be held stable while tvalid is high and tready is low.
REQ-023 Peak throughput SHALL be one half per cycle (one input beat per 2 cycles) with no bubble between consecutive input beats.
REQ-024 beat_count SHALL increment by 1 per accepted input beat and wrap from all-ones to 0.
REQ-025 chan_enable changes SHALL affect only halves whose dest is latched after the change; a pending half SHALL complete to its latched channel even if that channel is disabled.

Reset
REQ-026 While reset is high, the block SHALL immediately hold:
- state = EMPTY, rr = 1, dest = 1, holding register = 0, beat_count = 0;
- all chN_tvalid = 0, all chN_tdata = 0, adc_tready = 0.
REQ-027 Reset mid-operation SHALL discard any pending halves without emitting them. adc_tready SHALL rise no earlier than the first clock edge after reset deasserts.

Verification
REQ-028 Enable 3'b111, all readies high, beats D0, D1 back-to-back -> D0[127:0] on ch1, D0[255:128] on ch2, D1[127:0] on ch3, D1[255:128] on ch1, on consecutive cycles; beat_count = 2.
REQ-029 Enable 3'b101, one beat -> low half on ch1, high half on ch3; ch2_tvalid never high.
REQ-030 Enable 3'b111, ch2_tready low for 5 cycles during the high half -> ch2_tvalid and ch2_tdata stable for 5 cycles; adc_tready low during the stall; transfer completes on the cycle ch2_tready rises.
REQ-031 Low half pending to ch1, then chan_enable set to 3'b010 -> low half still delivered to ch1; high half goes to ch2.
REQ-032 chan_enable = 3'b000 with adc_tvalid high -> adc_tready stays 0; beat_count unchanged.
REQ-033 Reset asserted in HIGH state with beat_count = 0xFFFFFFFF -> all tvalid = 0 and beat_count = 0 without waiting for a clock edge; first beat after release routes to ch1.
